// File: rtl/video_bringup_sequencer.sv
// Power-up/recovery sequencer: PLL lock qualify -> client init -> pipeline reset hold -> run; re-sequences on lock loss or client drop-out.
// Latency: lock seen 2 cycles after the pin, control outputs one cycle behind the state register; no backpressure, pure level handshake with clients.
module video_bringup_sequencer #(
  parameter int NUM_CLIENTS  = 3,
  parameter int LOCK_STABLE  = 1024,
  parameter int INIT_TIMEOUT = 1000000,
  parameter int HOLD_CYCLES  = 93750000
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_pll_locked,
  input  logic [NUM_CLIENTS-1:0] i_init_done,
  output logic                   o_init_req,
  output logic                   o_master_reset,
  output logic                   o_rd_en,
  output logic [2:0]             o_state,
  output logic                   o_init_fault,
  output logic [7:0]             o_relock_count
);

  localparam int LW = $clog2(LOCK_STABLE + 1);
  localparam int TW = $clog2(INIT_TIMEOUT + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  localparam logic [LW-1:0] LOCK_MAX  = LW'(LOCK_STABLE);
  localparam logic [TW-1:0] TMO_MAX   = TW'(INIT_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST  = TW'(INIT_TIMEOUT - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_PLL_WAIT = 3'd0,
    ST_INIT     = 3'd1,
    ST_HOLD     = 3'd2,
    ST_RUN      = 3'd3,
    ST_FAULT    = 3'd4
  } state_t;

  state_t          r_state;
  logic            r_lock_meta;
  logic            r_lock_s;
  logic [LW-1:0]   r_stable_cnt;
  logic [TW-1:0]   r_init_cnt;
  logic [HW-1:0]   r_hold_cnt;
  logic [7:0]      r_relock_cnt;
  logic            r_init_fault;
  logic            r_init_req;
  logic            r_master_reset;
  logic            r_rd_en;

  logic            w_all_done;

  assign w_all_done = &i_init_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= ST_PLL_WAIT;
      r_lock_meta    <= 1'b0;
      r_lock_s       <= 1'b0;
      r_stable_cnt   <= '0;
      r_init_cnt     <= '0;
      r_hold_cnt     <= '0;
      r_relock_cnt   <= '0;
      r_init_fault   <= 1'b0;
      r_init_req     <= 1'b0;
      r_master_reset <= 1'b1;
      r_rd_en        <= 1'b0;
    end else begin
      r_lock_meta <= i_pll_locked;
      r_lock_s    <= r_lock_meta;

      if (!r_lock_s)
        r_stable_cnt <= '0;
      else if (r_stable_cnt != LOCK_MAX)
        r_stable_cnt <= r_stable_cnt + 1'b1;

      // Timers only run in their own state, so they read zero on every entry.
      if (r_state != ST_INIT)
        r_init_cnt <= '0;
      else if (r_init_cnt != TMO_MAX)
        r_init_cnt <= r_init_cnt + 1'b1;

      if (r_state != ST_HOLD)
        r_hold_cnt <= '0;
      else if (r_hold_cnt != HOLD_MAX)
        r_hold_cnt <= r_hold_cnt + 1'b1;

      case (r_state)
        ST_PLL_WAIT: begin
          if (r_lock_s && (r_stable_cnt == LOCK_MAX))
            r_state <= ST_INIT;
        end
        ST_INIT, ST_HOLD, ST_RUN: begin
          if (!r_lock_s) begin
            r_state <= ST_PLL_WAIT;
            if (r_relock_cnt != 8'hFF)
              r_relock_cnt <= r_relock_cnt + 8'd1;
          end else begin
            case (r_state)
              ST_INIT: begin
                if (w_all_done)
                  r_state <= ST_HOLD;
                else if (r_init_cnt == TMO_LAST) begin
                  r_state      <= ST_FAULT;
                  r_init_fault <= 1'b1;
                end
              end
              ST_HOLD: begin
                if (!w_all_done)
                  r_state <= ST_INIT;
                else if (r_hold_cnt == HOLD_LAST)
                  r_state <= ST_RUN;
              end
              default: begin
                if (!w_all_done)
                  r_state <= ST_INIT;
              end
            endcase
          end
        end
        default: r_state <= ST_FAULT;
      endcase

      r_init_req     <= (r_state == ST_INIT) || (r_state == ST_HOLD) || (r_state == ST_RUN);
      r_master_reset <= (r_state != ST_RUN);
      r_rd_en        <= (r_state == ST_RUN);
    end
  end

  assign o_init_req     = r_init_req;
  assign o_master_reset = r_master_reset;
  assign o_rd_en        = r_rd_en;
  assign o_state        = r_state;
  assign o_init_fault   = r_init_fault;
  assign o_relock_count = r_relock_cnt;

endmodule

// File: tb/tb_video_bringup_sequencer.sv
// Directed bench for video_bringup_sequencer with small timing parameters.
module tb_video_bringup_sequencer;

  logic       clk;
  logic       rst_n;
  logic       pll;
  logic [2:0] done;
  logic       init_req;
  logic       master_reset;
  logic       rd_en;
  logic [2:0] state;
  logic       init_fault;
  logic [7:0] relock;

  int n_tests;
  int n_fail;
  int e;

  video_bringup_sequencer #(
    .NUM_CLIENTS (3),
    .LOCK_STABLE (4),
    .INIT_TIMEOUT(20),
    .HOLD_CYCLES (8)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_pll_locked  (pll),
    .i_init_done   (done),
    .o_init_req    (init_req),
    .o_master_reset(master_reset),
    .o_rd_en       (rd_en),
    .o_state       (state),
    .o_init_fault  (init_fault),
    .o_relock_count(relock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // e is the index of the last rising edge passed; we always sit at a falling edge.
  task automatic adv(input int k);
    repeat (k - e) @(negedge clk);
    e = k;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, {29'd0, state}, 32'd0);
    chk({tag, "_mrst"}, {31'd0, master_reset}, 32'd1);
    chk({tag, "_ireq"}, {31'd0, init_req}, 32'd0);
    chk({tag, "_rden"}, {31'd0, rd_en}, 32'd0);
    chk({tag, "_fault"}, {31'd0, init_fault}, 32'd0);
    chk({tag, "_relock"}, {24'd0, relock}, 32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    pll     = 1'b0;
    done    = 3'b000;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Scenario 1: nominal bring-up.
    done = 3'b111;
    pll  = 1'b1;
    e    = -1;
    adv(5);  chk("s1_pllwait_e5", {29'd0, state}, 32'd0);
    adv(6);  chk("s1_init_e6", {29'd0, state}, 32'd1);
    adv(7);  chk("s1_hold_e7", {29'd0, state}, 32'd2);
             chk("s1_ireq_e7", {31'd0, init_req}, 32'd1);
    adv(14); chk("s1_hold_e14", {29'd0, state}, 32'd2);
    adv(15); chk("s1_run_e15", {29'd0, state}, 32'd3);
             chk("s1_mrst_e15", {31'd0, master_reset}, 32'd1);
             chk("s1_rden_e15", {31'd0, rd_en}, 32'd0);
    adv(16); chk("s1_mrst_e16", {31'd0, master_reset}, 32'd0);
             chk("s1_rden_e16", {31'd0, rd_en}, 32'd1);

    // Scenario 3: one-cycle lock drop in RUN.
    pll = 1'b0;
    adv(17);
    pll = 1'b1;
    adv(18); chk("s3_run_e18", {29'd0, state}, 32'd3);
    adv(19); chk("s3_pllwait_e19", {29'd0, state}, 32'd0);
             chk("s3_relock_e19", {24'd0, relock}, 32'd1);
    adv(20); chk("s3_mrst_e20", {31'd0, master_reset}, 32'd1);
             chk("s3_ireq_e20", {31'd0, init_req}, 32'd0);
             chk("s3_rden_e20", {31'd0, rd_en}, 32'd0);
    adv(23); chk("s3_pllwait_e23", {29'd0, state}, 32'd0);
    adv(24); chk("s3_init_e24", {29'd0, state}, 32'd1);
    adv(25); chk("s3_hold_e25", {29'd0, state}, 32'd2);
    adv(32); chk("s3_hold_e32", {29'd0, state}, 32'd2);
    adv(33); chk("s3_run_e33", {29'd0, state}, 32'd3);

    // Scenario 4: client drop-out in RUN, then in HOLD.
    done = 3'b101;
    adv(34); chk("s4_run2init", {29'd0, state}, 32'd1);
    done = 3'b111;
    adv(35); chk("s4_hold_e35", {29'd0, state}, 32'd2);
             chk("s4_mrst_e35", {31'd0, master_reset}, 32'd1);
             chk("s4_ireq_e35", {31'd0, init_req}, 32'd1);
    adv(37);
    done = 3'b101;
    adv(38); chk("s4_hold2init", {29'd0, state}, 32'd1);
    done = 3'b111;
    adv(39); chk("s4_hold_e39", {29'd0, state}, 32'd2);
    adv(46); chk("s4_hold_e46", {29'd0, state}, 32'd2);
    adv(47); chk("s4_run_e47", {29'd0, state}, 32'd3);

    // Scenario 5: lock loss and drop-out on the same cycle; lock loss wins.
    pll = 1'b0;
    adv(49); chk("s5_run_e49", {29'd0, state}, 32'd3);
    done = 3'b011;
    adv(50); chk("s5_pllwait", {29'd0, state}, 32'd0);
             chk("s5_relock", {24'd0, relock}, 32'd2);
    done = 3'b111;
    adv(54);
    for (int i = 0; i < 10; i++) begin
      pll = 1'b1;
      adv(e + 2);
      pll = 1'b0;
      adv(e + 1);
      chk($sformatf("s5_glitch_%0d", i), {29'd0, state}, 32'd0);
    end

    // Scenario 6a: asynchronous reset mid-HOLD.
    adv(e + 4);
    pll = 1'b1;
    e   = -1;
    adv(10); chk("s6_hold_e10", {29'd0, state}, 32'd2);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("s6_hold_rst");
    @(negedge clk);
    rst_n = 1'b1;
    e     = -1;

    // Scenario 6b: asynchronous reset mid-RUN.
    adv(15); chk("s6_run_e15", {29'd0, state}, 32'd3);
    adv(16); chk("s6_mrst_e16", {31'd0, master_reset}, 32'd0);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("s6_run_rst");
    @(negedge clk);
    pll   = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Scenario 6c: relock counter saturation.
    for (int i = 0; i < 300; i++) begin
      pll = 1'b1;
      e   = -1;
      adv(6);
      if (i == 0) chk("s6_loop_init", {29'd0, state}, 32'd1);
      pll = 1'b0;
      adv(9);
      if (i == 0)   chk("s6_relock_1", {24'd0, relock}, 32'd1);
      if (i == 254) chk("s6_relock_255", {24'd0, relock}, 32'd255);
    end
    chk("s6_relock_sat", {24'd0, relock}, 32'd255);
    chk("s6_sat_state", {29'd0, state}, 32'd0);

    // Scenario 2: init timeout into sticky FAULT.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    done  = 3'b011;
    pll   = 1'b1;
    rst_n = 1'b1;
    e     = -1;
    adv(6);  chk("s2_init_e6", {29'd0, state}, 32'd1);
    adv(25); chk("s2_init_e25", {29'd0, state}, 32'd1);
             chk("s2_nofault_e25", {31'd0, init_fault}, 32'd0);
    adv(26); chk("s2_fault_e26", {29'd0, state}, 32'd4);
             chk("s2_flag_e26", {31'd0, init_fault}, 32'd1);
    adv(27); chk("s2_mrst_e27", {31'd0, master_reset}, 32'd1);
             chk("s2_ireq_e27", {31'd0, init_req}, 32'd0);
             chk("s2_rden_e27", {31'd0, rd_en}, 32'd0);
    pll = 1'b0;
    adv(33);
    pll  = 1'b1;
    done = 3'b111;
    adv(45); chk("s2_fault_hold", {29'd0, state}, 32'd4);
             chk("s2_flag_hold", {31'd0, init_fault}, 32'd1);
             chk("s2_mrst_hold", {31'd0, master_reset}, 32'd1);
             chk("s2_relock_hold", {24'd0, relock}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
